pool2x2_line: RTL and testbench

- Parametrised 2x2 / stride-2 pooling stage for raster-scan feature-map streams, one pixel per enabled cycle.
- Successor to the fixed 16-bit, 32-column max pooler. Adds configurable data width, line depth and signedness.
- Adds a runtime max/average mode and line-overflow detection.
- Sits between a convolution/activation stage and the next layer; the line buffer is an internal register array.

---
 rtl/pool2x2_line.sv | 157 +++++++++++++++
 tb/tb_pool2x2_line.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_line.sv
// 2x2 / stride-2 max (optionally average) pooling over a raster-scan pixel stream.
// Define POOL2X2_AVG_EN to build the average path selected by mode=1; otherwise max-only.
module pool2x2_line #(
  parameter int DATA_W   = 16,
  parameter int MAX_LINE = 32,
  parameter int ADDR_W   = 5,
  parameter int SIGNED   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              frame_start_in,
  input  logic              line_start_in,
  input  logic              frame_end_in,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              mode,
  output logic [DATA_W-1:0] pool_out,
  output logic              valid,
  output logic              line_start_out,
  output logic              frame_start_out,
  output logic              frame_end_out,
  output logic              ovf_err
);

  typedef enum logic [1:0] {IDLE, TOP, BOT} state_t;

  // One spare counter bit lets col reach MAX_LINE even when 2^ADDR_W == MAX_LINE.
  localparam logic [ADDR_W:0] LINE_LIM = (ADDR_W+1)'(MAX_LINE);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   col_q, col_d;
  logic [DATA_W-1:0] linebuf [0:MAX_LINE-1];
  logic [DATA_W-1:0] held_q, latched_q, pool_q;
  logic              valid_q, lineStart_q, frameStart_q, frameEnd_q, ovf_q;
  logic              lsArm_q, fsArm_q;

  logic              accept, rowStart, rowBot, inRange;
  logic              doWrite, doHold, doPool, doDrop;
  logic [ADDR_W:0]   curCol;
  logic [ADDR_W-1:0] colIdx;
  logic [DATA_W-1:0] topRd, maxL, maxR, maxAll, result;

  function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign accept   = ena && ((state_q != IDLE) || frame_start_in);
  assign rowStart = frame_start_in || line_start_in;
  assign rowBot   = frame_start_in ? 1'b0 :
                    line_start_in  ? (state_q == TOP) : (state_q == BOT);
  assign curCol   = rowStart ? '0 : col_q;
  assign inRange  = curCol < LINE_LIM;
  assign colIdx   = curCol[ADDR_W-1:0];
  assign topRd    = linebuf[colIdx];

  assign doWrite = accept && !rowBot && inRange;
  assign doHold  = accept && rowBot && inRange && !curCol[0];
  assign doPool  = accept && rowBot && inRange && curCol[0];
  assign doDrop  = accept && !inRange;

  assign maxL   = greater(held_q, latched_q) ? held_q : latched_q;
  assign maxR   = greater(topRd, pix_in) ? topRd : pix_in;
  assign maxAll = greater(maxL, maxR) ? maxL : maxR;

`ifdef POOL2X2_AVG_EN
  logic              mode_q;
  logic [DATA_W+1:0] sum;

  function automatic logic [DATA_W+1:0] ext(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) return {{2{v[DATA_W-1]}}, v};
    return {2'b00, v};
  endfunction

  // Dropping the two LSBs of the widened sum is a floor divide for both signednesses.
  assign sum    = ext(held_q) + ext(latched_q) + ext(topRd) + ext(pix_in);
  assign result = mode_q ? sum[DATA_W+1:2] : maxAll;
`else
  assign result = maxAll;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    if (accept) begin
      if (rowStart) begin
        state_d = rowBot ? BOT : TOP;
        col_d   = (ADDR_W+1)'(1);
      end else if (col_q < LINE_LIM) begin
        col_d = col_q + (ADDR_W+1)'(1);
      end
      if (frame_end_in) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) linebuf[colIdx] <= pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      held_q       <= '0;
      latched_q    <= '0;
      pool_q       <= '0;
      valid_q      <= 1'b0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
      frameEnd_q   <= 1'b0;
      ovf_q        <= 1'b0;
      lsArm_q      <= 1'b0;
      fsArm_q      <= 1'b0;
`ifdef POOL2X2_AVG_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      valid_q      <= 1'b0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
      frameEnd_q   <= accept && frame_end_in;
      if (accept && frame_start_in) begin
        fsArm_q <= 1'b1;
        lsArm_q <= 1'b0;
        ovf_q   <= 1'b0;
`ifdef POOL2X2_AVG_EN
        mode_q  <= mode;
`endif
      end else if (accept && line_start_in && rowBot) begin
        lsArm_q <= 1'b1;
      end
      if (doDrop) ovf_q <= 1'b1;
      if (doHold) begin
        held_q    <= pix_in;
        latched_q <= topRd;
      end
      if (doPool) begin
        valid_q      <= 1'b1;
        pool_q       <= result;
        lineStart_q  <= lsArm_q;
        frameStart_q <= lsArm_q && fsArm_q;
        lsArm_q      <= 1'b0;
        fsArm_q      <= 1'b0;
      end
    end
  end

  assign pool_out        = pool_q;
  assign valid           = valid_q;
  assign line_start_out  = lineStart_q;
  assign frame_start_out = frameStart_q;
  assign frame_end_out   = frameEnd_q;
  assign ovf_err         = ovf_q;

endmodule

// File: tb/tb_pool2x2_line.sv
// Directed self-checking bench for pool2x2_line: default, SIGNED=1 and MAX_LINE=8 instances
// share one stimulus stream; each test checks the instance it targets.
module tb_pool2x2_line;

  logic        clk = 1'b0;
  logic        rst_n, ena, fsIn, lsIn, feIn, mode;
  logic [15:0] pixIn;

  logic [15:0] p0, pS, pO;
  logic        v0, ls0, fs0, fe0, ovf0;
  logic        vS, lsS, fsS, feS, ovfS;
  logic        vO, lsO, fsO, feO, ovfO;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lastEdge = 0;
  int fe0Count = 0;

  logic [15:0] q0Val[$];
  logic [2:0]  q0Flg[$];
  int          q0Cyc[$];
  logic [15:0] qSVal[$];
  logic [15:0] qOVal[$];
  int          oddEdge[$];
  logic [15:0] frameBuf [0:63];

  always #5 clk = ~clk;

  pool2x2_line dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_start_in(fsIn), .line_start_in(lsIn),
    .frame_end_in(feIn), .pix_in(pixIn), .mode(mode), .pool_out(p0), .valid(v0),
    .line_start_out(ls0), .frame_start_out(fs0), .frame_end_out(fe0), .ovf_err(ovf0));

  pool2x2_line #(.SIGNED(1)) dutS (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_start_in(fsIn), .line_start_in(lsIn),
    .frame_end_in(feIn), .pix_in(pixIn), .mode(mode), .pool_out(pS), .valid(vS),
    .line_start_out(lsS), .frame_start_out(fsS), .frame_end_out(feS), .ovf_err(ovfS));

  pool2x2_line #(.MAX_LINE(8), .ADDR_W(3)) dutO (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_start_in(fsIn), .line_start_in(lsIn),
    .frame_end_in(feIn), .pix_in(pixIn), .mode(mode), .pool_out(pO), .valid(vO),
    .line_start_out(lsO), .frame_start_out(fsO), .frame_end_out(feO), .ovf_err(ovfO));

  // Output monitor: records every valid beat one time unit after the edge that produced it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (v0 === 1'b1) begin
      q0Val.push_back(p0);
      q0Flg.push_back({ls0, fs0, fe0});
      q0Cyc.push_back(cyc);
    end
    if (fe0 === 1'b1) fe0Count = fe0Count + 1;
    if (vS === 1'b1) qSVal.push_back(pS);
    if (vO === 1'b1) qOVal.push_back(pO);
  end

  task automatic clearQueues();
    q0Val.delete(); q0Flg.delete(); q0Cyc.delete();
    qSVal.delete(); qOVal.delete(); oddEdge.delete();
    fe0Count = 0;
  endtask

  task automatic drivePix(input logic [15:0] p, input logic en, input logic fs,
                          input logic ls, input logic fe);
    @(negedge clk);
    pixIn = p; ena = en; fsIn = fs; lsIn = ls; feIn = fe;
    lastEdge = cyc + 1;
  endtask

  task automatic fillRaster(input int w, input int h);
    for (int i = 0; i < w * h; i++) frameBuf[i] = 16'(i + 1);
  endtask

  task automatic sendFrame(input int w, input int h, input bit toggle);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        drivePix(frameBuf[r*w+c], 1'b1, (r == 0 && c == 0), (c == 0), (r*w+c == w*h-1));
        if (r % 2 == 1 && c % 2 == 1) oddEdge.push_back(lastEdge);
        if (toggle) drivePix(16'hDEAD, 1'b0, 1'b1, 1'b1, 1'b1);
      end
    end
    for (int i = 0; i < 3; i++) drivePix(16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; fsIn = 1'b0; lsIn = 1'b0; feIn = 1'b0; mode = 1'b0; pixIn = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({v0, ls0, fs0, fe0, ovf0} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", {v0, ls0, fs0, fe0, ovf0});
    end
    checks++;
    if (p0 !== 16'h0) begin
      errors++; $display("[TB] FAIL reset_pool: got %h expected 0000", p0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_max_unsigned();
    logic [15:0] expV [0:3];
    logic [2:0]  expF [0:3];
    expV = '{16'd6, 16'd8, 16'd14, 16'd16};
    expF = '{3'b110, 3'b000, 3'b100, 3'b001};
    clearQueues();
    mode = 1'b0;
    drivePix(16'd99, 1'b1, 1'b0, 1'b1, 1'b0);
    fillRaster(4, 4);
    sendFrame(4, 4, 1'b0);
    checks++;
    if (q0Val.size() != 4) begin
      errors++; $display("[TB] FAIL max_count: got %0d expected 4", q0Val.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q0Val.size() || q0Val[i] !== expV[i] || q0Flg[i] !== expF[i]) begin
        errors++;
        $display("[TB] FAIL max_out%0d: got %0d flags %b expected %0d flags %b", i,
                 (i < q0Val.size()) ? q0Val[i] : 16'hFFFF,
                 (i < q0Flg.size()) ? q0Flg[i] : 3'b111, expV[i], expF[i]);
      end
    end
    checks++;
    if (fe0Count != 1) begin
      errors++; $display("[TB] FAIL max_fe_pulses: got %0d expected 1", fe0Count);
    end
    checks++;
    if (p0 !== 16'd16 || v0 !== 1'b0) begin
      errors++; $display("[TB] FAIL max_hold: got %0d valid %b expected 16 valid 0", p0, v0);
    end
  endtask

  task automatic test_mode_avg();
    logic [15:0] expV [0:3];
`ifdef POOL2X2_AVG_EN
    expV = '{16'd3, 16'd5, 16'd11, 16'd13};
`else
    expV = '{16'd6, 16'd8, 16'd14, 16'd16};
`endif
    clearQueues();
    mode = 1'b1;
    fillRaster(4, 4);
    sendFrame(4, 4, 1'b0);
    mode = 1'b0;
    checks++;
    if (q0Val.size() != 4) begin
      errors++; $display("[TB] FAIL avg_count: got %0d expected 4", q0Val.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q0Val.size() || q0Val[i] !== expV[i]) begin
        errors++;
        $display("[TB] FAIL avg_out%0d: got %0d expected %0d", i,
                 (i < q0Val.size()) ? q0Val[i] : 16'hFFFF, expV[i]);
      end
    end
  endtask

  task automatic test_signed();
    logic [15:0] expS [0:2];
`ifdef POOL2X2_AVG_EN
    expS = '{16'hFFFF, 16'hFFFD, 16'h0003};
`else
    expS = '{16'hFFFF, 16'hFFFF, 16'h0003};
`endif
    clearQueues();
    frameBuf[0] = 16'hFFFB; frameBuf[1] = 16'hFFFD; frameBuf[2] = 16'hFFFF; frameBuf[3] = 16'hFFFE;
    mode = 1'b0; sendFrame(2, 2, 1'b0);
    mode = 1'b1; sendFrame(2, 2, 1'b0);
    frameBuf[0] = 16'hFFFB; frameBuf[1] = 16'h0003; frameBuf[2] = 16'h0001; frameBuf[3] = 16'h0002;
    mode = 1'b0; sendFrame(2, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= qSVal.size() || qSVal[i] !== expS[i]) begin
        errors++;
        $display("[TB] FAIL signed_out%0d: got %h expected %h", i,
                 (i < qSVal.size()) ? qSVal[i] : 16'hDEAD, expS[i]);
      end
    end
    checks++;
    if (q0Val.size() != 3 || q0Val[2] !== 16'hFFFB) begin
      errors++;
      $display("[TB] FAIL unsigned_cmp: got %h expected fffb",
               (q0Val.size() == 3) ? q0Val[2] : 16'hDEAD);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] expO [0:3];
    expO = '{16'd12, 16'd14, 16'd16, 16'd18};
    clearQueues();
    fillRaster(10, 2);
    for (int i = 0; i < 20; i++) begin
      drivePix(frameBuf[i], 1'b1, (i == 0), (i % 10 == 0), (i == 19));
      if (i == 7 || i == 8) begin
        @(posedge clk); #2;
        checks++;
        if (ovfO !== (i == 8)) begin
          errors++; $display("[TB] FAIL ovf_pix%0d: got %b expected %b", i + 1, ovfO, (i == 8));
        end
      end
    end
    for (int i = 0; i < 3; i++) drivePix(16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ovfO !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", ovfO);
    end
    checks++;
    if (qOVal.size() != 4) begin
      errors++; $display("[TB] FAIL ovf_count: got %0d expected 4", qOVal.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= qOVal.size() || qOVal[i] !== expO[i]) begin
        errors++;
        $display("[TB] FAIL ovf_out%0d: got %0d expected %0d", i,
                 (i < qOVal.size()) ? qOVal[i] : 16'hFFFF, expO[i]);
      end
    end
    drivePix(16'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #2;
    checks++;
    if (ovfO !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", ovfO);
    end
    drivePix(16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ena_toggle();
    logic [15:0] expV [0:3];
    expV = '{16'd6, 16'd8, 16'd14, 16'd16};
    clearQueues();
    mode = 1'b0;
    drivePix(16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1);
    fillRaster(4, 4);
    sendFrame(4, 4, 1'b1);
    checks++;
    if (q0Val.size() != 4 || oddEdge.size() != 4) begin
      errors++; $display("[TB] FAIL toggle_count: got %0d expected 4", q0Val.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q0Val.size() || i >= oddEdge.size() || q0Val[i] !== expV[i] || q0Cyc[i] != oddEdge[i]) begin
        errors++;
        $display("[TB] FAIL toggle_out%0d: got %0d at edge %0d expected %0d at edge %0d", i,
                 (i < q0Val.size()) ? q0Val[i] : 16'hFFFF, (i < q0Cyc.size()) ? q0Cyc[i] : -1,
                 expV[i], (i < oddEdge.size()) ? oddEdge[i] : -1);
      end
    end
  endtask

  task automatic test_odd_and_reset();
    logic [15:0] expV [0:3];
    clearQueues();
    mode = 1'b0;
    fillRaster(5, 3);
    for (int i = 0; i < 12; i++) drivePix(frameBuf[i], 1'b1, (i == 0), (i % 5 == 0), 1'b0);
    @(negedge clk);
    checks++;
    if (q0Val.size() != 2 || q0Val[0] !== 16'd7 || q0Val[1] !== 16'd9) begin
      errors++;
      $display("[TB] FAIL odd_outputs: got count %0d first %0d expected count 2 values 7 9",
               q0Val.size(), (q0Val.size() > 0) ? q0Val[0] : 16'hFFFF);
    end
    rst_n = 1'b0; ena = 1'b0; fsIn = 1'b0; lsIn = 1'b0; feIn = 1'b0;
    #2;
    checks++;
    if ({p0, v0, ls0, fs0, fe0, ovf0} !== 21'b0) begin
      errors++; $display("[TB] FAIL midframe_reset: got pool %0d flags %b expected all 0",
                         p0, {v0, ls0, fs0, fe0, ovf0});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearQueues();
    expV = '{16'd6, 16'd8, 16'd14, 16'd16};
    fillRaster(4, 4);
    sendFrame(4, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q0Val.size() || q0Val[i] !== expV[i]) begin
        errors++;
        $display("[TB] FAIL after_reset_out%0d: got %0d expected %0d", i,
                 (i < q0Val.size()) ? q0Val[i] : 16'hFFFF, expV[i]);
      end
    end
    checks++;
    if (q0Flg.size() < 1 || q0Flg[0] !== 3'b110) begin
      errors++; $display("[TB] FAIL after_reset_flags: got %b expected 110",
                         (q0Flg.size() > 0) ? q0Flg[0] : 3'b111);
    end
  endtask

  initial begin
    test_reset();
    test_max_unsigned();
    test_mode_avg();
    test_signed();
    test_overflow();
    test_ena_toggle();
    test_odd_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
